// File: rtl/decode_pipe_stage_if.sv
// rtl/decode_pipe_stage_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface decode_pipe_stage_if #(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [PC_WIDTH-1:0] in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  logic [4:0]          rs1_addr;
  logic [4:0]          rs2_addr;
  logic [4:0]          rd_addr;
  logic [2:0]          funct3;
  logic [XLEN-1:0]     imm;
  logic [3:0]          alu_op;
  logic                reg_write;
  logic                alu_src;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic                branch;
  logic                jump;
  logic                jump_reg;
  logic                illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, rs1_addr, rs2_addr, rd_addr, funct3, imm, alu_op,
           reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, jump_reg, illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, rs1_addr, rs2_addr, rd_addr, funct3, imm, alu_op,
           reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, jump_reg, illegal
  );
endinterface

// File: rtl/decode_pipe_stage.sv
// rtl/decode_pipe_stage.sv - registered RISC-V decode stage with valid/ready, backpressure and flush
// Optional M-extension decode is enabled by defining DECODE_M_EXT_EN.
module decode_pipe_stage #(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  decode_pipe_stage_if.slave bus
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;
`ifdef DECODE_M_EXT_EN
  localparam logic [6:0] F7_MUL   = 7'b0000001;
  localparam logic [3:0] ALU_MUL  = 4'd11;
  localparam logic [3:0] ALU_MULH = 4'd12;
  localparam logic [3:0] ALU_DIV  = 4'd13;
  localparam logic [3:0] ALU_REM  = 4'd14;
`endif

  // alt selects SUB/SRA; callers only raise it where instr[30] is meaningful
  function automatic logic [3:0] base_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  base_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  logic [31:0]         ins;
  logic [6:0]          opcode;
  logic [6:0]          funct7;
  logic [2:0]          f3;
  logic [PC_WIDTH-1:0] pc_d;
  logic [XLEN-1:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0]     d_imm;
  logic [3:0]          d_alu;
  logic                d_rw, d_as, d_mr, d_mw, d_mtr, d_br, d_j, d_jr, d_ill;
  logic                capture;

  assign ins    = bus.in_instr;
  assign pc_d   = bus.in_pc;
  assign opcode = ins[6:0];
  assign funct7 = ins[31:25];
  assign f3     = ins[14:12];

  assign imm_i = {{(XLEN-12){ins[31]}}, ins[31:20]};
  assign imm_s = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  always_comb begin
    d_imm = '0;
    d_alu = ALU_ADD;
    d_rw  = 1'b0;
    d_as  = 1'b0;
    d_mr  = 1'b0;
    d_mw  = 1'b0;
    d_mtr = 1'b0;
    d_br  = 1'b0;
    d_j   = 1'b0;
    d_jr  = 1'b0;
    d_ill = 1'b0;
    case (opcode)
      OP_R: begin
        d_rw = 1'b1;
        if (funct7 == F7_BASE || (funct7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)))
          d_alu = base_op(f3, funct7[5]);
`ifdef DECODE_M_EXT_EN
        else if (funct7 == F7_MUL)
          d_alu = (f3 == 3'b000) ? ALU_MUL  :
                  (!f3[2])       ? ALU_MULH :
                  (!f3[1])       ? ALU_DIV  : ALU_REM;
`endif
        else
          d_ill = 1'b1;
      end
      OP_IMM: begin
        d_rw  = 1'b1;
        d_as  = 1'b1;
        d_imm = imm_i;
        if (f3 == 3'b001) begin
          d_alu = ALU_SLL;
          d_ill = (funct7 != F7_BASE);
        end else if (f3 == 3'b101) begin
          d_alu = funct7[5] ? ALU_SRA : ALU_SRL;
          d_ill = !(funct7 == F7_BASE || funct7 == F7_ALT);
        end else begin
          d_alu = base_op(f3, 1'b0);
        end
      end
      OP_LOAD: begin
        d_rw = 1'b1; d_as = 1'b1; d_mr = 1'b1; d_mtr = 1'b1; d_imm = imm_i;
      end
      OP_STORE:  begin d_mw = 1'b1; d_imm = imm_s; end
      OP_BRANCH: begin d_br = 1'b1; d_alu = ALU_SUB; d_imm = imm_b; end
      OP_JAL:    begin d_rw = 1'b1; d_j = 1'b1; d_imm = imm_j; end
      OP_JALR: begin
        d_rw = 1'b1; d_as = 1'b1; d_j = 1'b1; d_jr = 1'b1; d_imm = imm_i;
      end
      OP_LUI:    begin d_rw = 1'b1; d_as = 1'b1; d_alu = ALU_PASSB; d_imm = imm_u; end
      OP_AUIPC:  begin d_rw = 1'b1; d_as = 1'b1; d_imm = imm_u; end
      default:   d_ill = 1'b1;
    endcase
    // an illegal bundle must carry no side effects into execute, only the trap flag
    if (d_ill) begin
      d_alu = ALU_ADD;
      d_rw  = 1'b0; d_as = 1'b0; d_mr = 1'b0; d_mw = 1'b0;
      d_mtr = 1'b0; d_br = 1'b0; d_j  = 1'b0; d_jr = 1'b0;
    end
    if (ins[11:7] == 5'd0)
      d_rw = 1'b0;
  end

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_pc     <= '0;
      bus.rs1_addr   <= '0;
      bus.rs2_addr   <= '0;
      bus.rd_addr    <= '0;
      bus.funct3     <= '0;
      bus.imm        <= '0;
      bus.alu_op     <= '0;
      bus.reg_write  <= 1'b0;
      bus.alu_src    <= 1'b0;
      bus.mem_read   <= 1'b0;
      bus.mem_write  <= 1'b0;
      bus.mem_to_reg <= 1'b0;
      bus.branch     <= 1'b0;
      bus.jump       <= 1'b0;
      bus.jump_reg   <= 1'b0;
      bus.illegal    <= 1'b0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (capture) begin
      bus.out_valid  <= 1'b1;
      bus.out_pc     <= pc_d;
      bus.rs1_addr   <= ins[19:15];
      bus.rs2_addr   <= ins[24:20];
      bus.rd_addr    <= ins[11:7];
      bus.funct3     <= f3;
      bus.imm        <= d_imm;
      bus.alu_op     <= d_alu;
      bus.reg_write  <= d_rw;
      bus.alu_src    <= d_as;
      bus.mem_read   <= d_mr;
      bus.mem_write  <= d_mw;
      bus.mem_to_reg <= d_mtr;
      bus.branch     <= d_br;
      bus.jump       <= d_j;
      bus.jump_reg   <= d_jr;
      bus.illegal    <= d_ill;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_pipe_stage.sv
// tb/tb_decode_pipe_stage.sv - scoreboard bench for decode_pipe_stage (32-bit and 64-bit instances)
module tb_decode_pipe_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [7:0]  ctl;
    logic        ill;
  } bundle_t;

  localparam logic [31:0] I_ADD  = 32'h007302b3;
  localparam logic [31:0] I_ADDI = 32'hfff10093;
  localparam logic [31:0] I_SW   = 32'h0040a623;
  localparam logic [31:0] I_BEQ  = 32'h00208263;
  localparam logic [31:0] I_JAL  = 32'h008000ef;
  localparam logic [31:0] I_LUI  = 32'h123453b7;
  localparam logic [31:0] I_ZERO = 32'h00000000;
  localparam logic [31:0] I_MUL  = 32'h02c58533;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   total = 0;
  int   bad = 0;
  logic mv = 1'b0;
  bundle_t sbq[$];

  always #5 clk = ~clk;

  decode_pipe_stage_if #(.XLEN(32), .PC_WIDTH(32)) vif();
  decode_pipe_stage_if #(.XLEN(64), .PC_WIDTH(32)) vif64();

  decode_pipe_stage #(.XLEN(32), .PC_WIDTH(32)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(vif));
  decode_pipe_stage #(.XLEN(64), .PC_WIDTH(32)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(vif64));

  assign vif64.in_valid  = vif.in_valid;
  assign vif64.in_instr  = vif.in_instr;
  assign vif64.in_pc     = vif.in_pc;
  assign vif64.out_ready = vif.out_ready;

  function automatic bundle_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] imm,
                                 input logic [3:0] alu, input logic [7:0] ctl, input logic ill);
    mk = {pc, rs1, rs2, rd, f3, imm, alu, ctl, ill};
  endfunction

  function automatic bundle_t obs();
    obs = {vif.out_pc, vif.rs1_addr, vif.rs2_addr, vif.rd_addr, vif.funct3, vif.imm, vif.alu_op,
           vif.reg_write, vif.alu_src, vif.mem_read, vif.mem_write, vif.mem_to_reg,
           vif.branch, vif.jump, vif.jump_reg, vif.illegal};
  endfunction

  function automatic bundle_t e_mul(input logic [31:0] pc);
`ifdef DECODE_M_EXT_EN
    e_mul = mk(pc, 5'd11, 5'd12, 5'd10, 3'd0, 32'd0, 4'd11, 8'h80, 1'b0);
`else
    e_mul = mk(pc, 5'd11, 5'd12, 5'd10, 3'd0, 32'd0, 4'd0, 8'h00, 1'b1);
`endif
  endfunction

  // one cycle of stimulus; the bench's own handshake model decides what is accepted or consumed
  task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                      input logic ordy, input logic fl, input bundle_t exp);
    logic acc;
    vif.in_valid  = v;
    vif.in_instr  = instr;
    vif.in_pc     = pc;
    vif.out_ready = ordy;
    flush         = fl;
    acc = v && (!mv || ordy) && !fl;
    if (mv && (ordy || fl) && sbq.size() > 0) void'(sbq.pop_front());
    if (acc) sbq.push_back(exp);
    mv = fl ? 1'b0 : (acc ? 1'b1 : (ordy ? 1'b0 : mv));
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1;
    vif.in_valid = 1'b1; vif.in_instr = I_ADD; vif.in_pc = 32'h40; vif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (vif.out_valid !== 1'b0 || obs() !== bundle_t'('0)) begin
      bad++; $display("FAIL reset: valid=%b got=%h want=0", vif.out_valid, obs());
    end
    total++;
    if (vif.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got=%b want=1", vif.in_ready); end
    total++;
    if (vif64.imm !== 64'd0) begin bad++; $display("FAIL reset_imm64: got=%h want=0", vif64.imm); end
    rst = 1'b0; flush = 1'b0; vif.in_valid = 1'b0; mv = 1'b0; sbq.delete();
    @(negedge clk);
  endtask

  task automatic test_alu();
    bundle_t e, ea;
    ea = mk(32'h100, 5'd6, 5'd7, 5'd5, 3'd0, 32'd0, 4'd0, 8'h80, 1'b0);
    step(1'b1, I_ADD, 32'h100, 1'b1, 1'b0, ea);
    e = (sbq.size() > 0) ? sbq[0] : '0;
    total++;
    if (vif.out_valid !== 1'b1 || obs() !== e) begin
      bad++; $display("FAIL add: valid=%b got=%h want=%h", vif.out_valid, obs(), e);
    end
    step(1'b0, I_ZERO, 32'h0, 1'b1, 1'b0, '0);
    total++;
    if (vif.out_valid !== 1'b0 || obs() !== ea) begin
      bad++; $display("FAIL add_drain_hold: valid=%b got=%h want=%h", vif.out_valid, obs(), ea);
    end
  endtask

  task automatic test_back_to_back();
    bundle_t e;
    step(1'b1, I_ADDI, 32'h110, 1'b1, 1'b0, mk(32'h110, 5'd2, 5'd31, 5'd1, 3'd0, 32'hffffffff, 4'd0, 8'hC0, 1'b0));
    e = (sbq.size() > 0) ? sbq[0] : '0;
    total++;
    if (vif.out_valid !== 1'b1 || obs() !== e) begin
      bad++; $display("FAIL addi: valid=%b got=%h want=%h", vif.out_valid, obs(), e);
    end
    total++;
    if (vif64.out_valid !== 1'b1 || vif64.imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      bad++; $display("FAIL addi_imm64: valid=%b got=%h want=ffffffffffffffff", vif64.out_valid, vif64.imm);
    end
    total++;
    if (vif.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready: got=%b want=1", vif.in_ready); end
    step(1'b1, I_SW, 32'h114, 1'b1, 1'b0, mk(32'h114, 5'd1, 5'd4, 5'd12, 3'd2, 32'd12, 4'd0, 8'h10, 1'b0));
    e = (sbq.size() > 0) ? sbq[0] : '0;
    total++;
    if (vif.out_valid !== 1'b1 || obs() !== e) begin
      bad++; $display("FAIL sw: valid=%b got=%h want=%h", vif.out_valid, obs(), e);
    end
    step(1'b0, I_ZERO, 32'h0, 1'b1, 1'b0, '0);
    total++;
    if (vif.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: valid=%b want=0", vif.out_valid); end
  endtask

  task automatic test_formats();
    logic [31:0] ins[3];
    bundle_t     exps[3];
    bundle_t     e;
    ins[0] = I_BEQ; exps[0] = mk(32'h200, 5'd1, 5'd2, 5'd4, 3'd0, 32'd4, 4'd1, 8'h04, 1'b0);
    ins[1] = I_JAL; exps[1] = mk(32'h204, 5'd0, 5'd8, 5'd1, 3'd0, 32'd8, 4'd0, 8'h82, 1'b0);
    ins[2] = I_LUI; exps[2] = mk(32'h208, 5'd8, 5'd3, 5'd7, 3'd5, 32'h12345000, 4'd10, 8'hC0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ins[i], 32'h200 + 32'(4 * i), 1'b1, 1'b0, exps[i]);
      e = (sbq.size() > 0) ? sbq[0] : '0;
      total++;
      if (vif.out_valid !== 1'b1 || obs() !== e) begin
        bad++; $display("FAIL format_%0d: valid=%b got=%h want=%h", i, vif.out_valid, obs(), e);
      end
    end
    step(1'b0, I_ZERO, 32'h0, 1'b1, 1'b0, '0);
  endtask

  task automatic test_backpressure();
    bundle_t e, ehold;
    ehold = mk(32'h300, 5'd2, 5'd31, 5'd1, 3'd0, 32'hffffffff, 4'd0, 8'hC0, 1'b0);
    step(1'b1, I_ADDI, 32'h300, 1'b0, 1'b0, ehold);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, I_ADD, 32'h304, 1'b0, 1'b0, mk(32'h304, 5'd6, 5'd7, 5'd5, 3'd0, 32'd0, 4'd0, 8'h80, 1'b0));
      total++;
      if (vif.out_valid !== 1'b1 || vif.in_ready !== 1'b0 || obs() !== ehold) begin
        bad++; $display("FAIL stall_%0d: valid=%b ready=%b got=%h want=%h", i, vif.out_valid, vif.in_ready, obs(), ehold);
      end
    end
    step(1'b1, I_ADD, 32'h304, 1'b1, 1'b0, mk(32'h304, 5'd6, 5'd7, 5'd5, 3'd0, 32'd0, 4'd0, 8'h80, 1'b0));
    e = (sbq.size() > 0) ? sbq[0] : '0;
    total++;
    if (vif.out_valid !== 1'b1 || obs() !== e) begin
      bad++; $display("FAIL after_stall: valid=%b got=%h want=%h", vif.out_valid, obs(), e);
    end
    step(1'b0, I_ZERO, 32'h0, 1'b1, 1'b0, '0);
  endtask

  task automatic test_flush();
    bundle_t e;
    step(1'b1, I_ADDI, 32'h400, 1'b1, 1'b0, mk(32'h400, 5'd2, 5'd31, 5'd1, 3'd0, 32'hffffffff, 4'd0, 8'hC0, 1'b0));
    e = (sbq.size() > 0) ? sbq[0] : '0;
    total++;
    if (vif.out_valid !== 1'b1 || obs() !== e) begin
      bad++; $display("FAIL pre_flush: valid=%b got=%h want=%h", vif.out_valid, obs(), e);
    end
    step(1'b1, I_LUI, 32'h404, 1'b0, 1'b1, mk(32'h404, 5'd8, 5'd3, 5'd7, 3'd5, 32'h12345000, 4'd10, 8'hC0, 1'b0));
    total++;
    if (vif.out_valid !== 1'b0) begin bad++; $display("FAIL flush: valid=%b want=0", vif.out_valid); end
    step(1'b0, I_ZERO, 32'h0, 1'b1, 1'b0, '0);
    total++;
    if (vif.out_valid !== 1'b0 || vif.out_pc === 32'h404) begin
      bad++; $display("FAIL flush_dropped: valid=%b pc=%h want valid=0 and pc!=404", vif.out_valid, vif.out_pc);
    end
    step(1'b1, I_LUI, 32'h408, 1'b0, 1'b0, mk(32'h408, 5'd8, 5'd3, 5'd7, 3'd5, 32'h12345000, 4'd10, 8'hC0, 1'b0));
    step(1'b1, I_ADD, 32'h40c, 1'b0, 1'b0, '0);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (vif.out_valid !== 1'b0 || obs() !== bundle_t'('0)) begin
      bad++; $display("FAIL reset_mid_stall: valid=%b got=%h want=0", vif.out_valid, obs());
    end
    rst = 1'b0; vif.in_valid = 1'b0; mv = 1'b0; sbq.delete();
    @(negedge clk);
  endtask

  task automatic test_illegal();
    bundle_t e;
    step(1'b1, I_ZERO, 32'h500, 1'b1, 1'b0, mk(32'h500, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 4'd0, 8'h00, 1'b1));
    e = (sbq.size() > 0) ? sbq[0] : '0;
    total++;
    if (vif.out_valid !== 1'b1 || obs() !== e) begin
      bad++; $display("FAIL zero_illegal: valid=%b got=%h want=%h", vif.out_valid, obs(), e);
    end
    step(1'b1, I_MUL, 32'h504, 1'b1, 1'b0, e_mul(32'h504));
    e = (sbq.size() > 0) ? sbq[0] : '0;
    total++;
    if (vif.out_valid !== 1'b1 || obs() !== e) begin
      bad++; $display("FAIL mul: valid=%b got=%h want=%h", vif.out_valid, obs(), e);
    end
    step(1'b0, I_ZERO, 32'h0, 1'b1, 1'b0, '0);
    total++;
    if (vif.out_valid !== 1'b0) begin bad++; $display("FAIL illegal_drain: valid=%b want=0", vif.out_valid); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_formats();
    test_backpressure();
    test_flush();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
